max7219_matrix_display: RTL and testbench
=========================================

MAX7219_MATRIX_DISPLAY -- requirements
Module: max7219_matrix_display

Interface
REQ-001 SHALL have parameter SIZE, default 2: number of daisy-chained MAX7219 8x8 devices, range 1..8.
REQ-002 SHALL have parameter INTENSITY, default 4'h8: value written to the intensity register during init.
REQ-003 SHALL have port clk, input, 1 bit: serial clock; the same net is routed to the MAX7219 CLK pin.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: request to refresh the display from pixels.
REQ-006 SHALL have port pixels, input, 64*SIZE bits: frame; device d, row r (0..7) = pixels[64*d+8*r +: 8].
REQ-007 SHALL have port started, output, 1 bit: init sequence complete, ready to accept enable.
REQ-008 SHALL have port mosi, output, 1 bit: serial data to the DIN pin of the first device.
REQ-009 SHALL have port cs, output, 1 bit: active-low load; devices latch on its rising edge.

Function
REQ-010 SHALL transmit data in frames: cs low for exactly 16*SIZE clk cycles, then cs high for exactly 2 cycles (gap); frame length F = 16*SIZE+2 (34 for SIZE=2).
REQ-011 SHALL send one 16-bit word per device per frame, MSB first: device SIZE-1 first, device 0 last, so device 0 sits nearest mosi.
REQ-012 SHALL update mosi and cs on the falling edge of clk, so the devices sample stable data on the rising edge.
REQ-013 SHALL use these states: INIT (send init frames), READY (idle, started=1), UPDATE (send row frames).
REQ-014 SHALL enter INIT after reset and send 5 frames, each word identical for all devices, in order: 0x0C01 (normal operation), 0x0900 (no decode), {8'h0A,4'h0,INTENSITY}, 0x0B07 (scan all 8 rows), 0x0F00 (display test off).
REQ-015 SHALL raise started on the first cycle after the last init gap, i.e. 5*F cycles after reset release, and hold it high until the next reset.
REQ-016 SHALL, in READY with enable=1 sampled on a rising edge, capture pixels into an internal register that same edge and enter UPDATE.
REQ-017 SHALL, in UPDATE, send 8 frames for r=0..7; the word for device d = {4'h0, r+1 (4 bits), pixels_reg[64*d+8*r +: 8]}.
REQ-018 SHALL return to READY after the eighth gap; UPDATE takes 8*F cycles (272 for SIZE=2).
REQ-019 SHALL ignore enable during INIT and UPDATE (no queuing).
REQ-020 SHALL use only pixels_reg during UPDATE; changes on pixels during UPDATE SHALL not affect the frames being sent.
REQ-021 SHALL, when enable is held high, start the next UPDATE on the first rising edge in READY, giving back-to-back refreshes with no extra idle cycle.
REQ-022 SHALL hold cs=1 and mosi=0 whenever no frame is being shifted (READY and gaps).

Reset
REQ-023 SHALL, while reset_n=0: cs=1, mosi=0, started=0, state INIT with frame and bit counters 0, pixels_reg=0.
REQ-024 SHALL, on reset mid-frame, abort immediately with no partial latch pulse beyond cs returning high, and restart the full init sequence after release.

Configuration
REQ-025 SHALL, with macro MAX7219_MIRROR_EN defined, bit-reverse each row data byte before transmission (horizontal mirror); without it, bytes SHALL be sent as specified in REQ-017.

Structure
REQ-026 SHALL place MAX7219 register address constants (0x01-0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0F), the gap length and the state encoding in a shared package max7219_pkg.
REQ-027 SHALL implement the frame serializer as a sub-module max7219_frame_tx: load 16*SIZE-bit word vector, shift it out, and generate cs and the gap.
REQ-028 SHALL treat the clock source (PLL producing clk, also exported as the device clock) as external to this block.

Verification
REQ-029 Scenario: reset release, SIZE=2 -> first frame bits = 0x0C010C01, cs low for 32 cycles, then high for 2; started=1 exactly 170 cycles after release.
REQ-030 Scenario: pixels=128'h0 except pixels[7:0]=8'hA5, enable pulse in READY -> row-0 frame = 0x0100_01A5; other rows send data 0x00; started stays high; back in READY 272 cycles later.
REQ-031 Scenario: enable pulse, then pixels toggled to all-ones during UPDATE -> all transmitted bytes match the captured value.
REQ-032 Scenario: enable held high -> second UPDATE's first cs fall occurs exactly 272 cycles after the first.
REQ-033 Scenario: reset_n pulsed low at bit 10 of row 3 -> cs=1 and mosi=0 immediately, started=0, and the init frame 0x0C010C01 replays after release.
REQ-034 Scenario: MAX7219_MIRROR_EN defined, row byte 8'h01 -> transmitted data byte 8'h80.

Source files
------------

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 register addresses, frame timing constants and controller state encoding
package max7219_pkg;

    localparam logic [7:0] ADDR_DIGIT0       = 8'h01;
    localparam logic [7:0] ADDR_DECODE       = 8'h09;
    localparam logic [7:0] ADDR_INTENSITY    = 8'h0A;
    localparam logic [7:0] ADDR_SCAN_LIMIT   = 8'h0B;
    localparam logic [7:0] ADDR_SHUTDOWN     = 8'h0C;
    localparam logic [7:0] ADDR_DISPLAY_TEST = 8'h0F;

    localparam int GAP_LEN     = 2;
    localparam int INIT_FRAMES = 5;
    localparam int ROW_FRAMES  = 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_READY,
        ST_UPDATE
    } state_t;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
        case (idx)
            3'd0:    init_word = {ADDR_SHUTDOWN, 8'h01};
            3'd1:    init_word = {ADDR_DECODE, 8'h00};
            3'd2:    init_word = {ADDR_INTENSITY, 4'h0, intensity};
            3'd3:    init_word = {ADDR_SCAN_LIMIT, 8'h07};
            default: init_word = {ADDR_DISPLAY_TEST, 8'h00};
        endcase
    endfunction

    // Rows 0..7 map onto digit registers 0x01..0x08.
    function automatic logic [7:0] row_addr(input logic [2:0] row);
        row_addr = ADDR_DIGIT0 + {5'd0, row};
    endfunction

endpackage

// File: rtl/max7219_frame_tx.sv
// rtl/max7219_frame_tx.sv - shifts one word per device MSB first, then holds cs high for the inter-frame gap
module max7219_frame_tx
    import max7219_pkg::*;
#(
    parameter int          SIZE       = 2,
    parameter logic [15:0] RESET_WORD = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [16*SIZE-1:0]   words,
    output logic                 frame_end,
    output logic                 mosi,
    output logic                 cs
);
    localparam int BITS = 16 * SIZE;
    localparam int FLEN = BITS + GAP_LEN;
    localparam int CW   = $clog2(FLEN);
    localparam logic [CW-1:0] LAST  = CW'(FLEN - 1);
    localparam logic [CW-1:0] NBITS = CW'(BITS);

    logic [CW-1:0]   bit_cnt;
    logic [BITS-1:0] shreg;

    // bit_cnt parks on the last gap slot when no new frame is loaded, which keeps cs high while idle.
    assign frame_end = (bit_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shreg   <= {SIZE{RESET_WORD}};
        end else if (frame_end) begin
            if (load) begin
                bit_cnt <= '0;
                shreg   <= words;
            end
        end else begin
            bit_cnt <= bit_cnt + CW'(1);
            shreg   <= shreg << 1;
        end
    end

    // Pins change on the falling edge so the devices see settled data on the rising edge.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs   <= 1'b1;
            mosi <= 1'b0;
        end else begin
            cs   <= (bit_cnt >= NBITS);
            mosi <= (bit_cnt < NBITS) && shreg[BITS-1];
        end
    end

endmodule

// File: rtl/max7219_matrix_display.sv
// rtl/max7219_matrix_display.sv - MAX7219 chain init and row refresh controller; MAX7219_MIRROR_EN mirrors each row byte
module max7219_matrix_display
    import max7219_pkg::*;
#(
    parameter int         SIZE      = 2,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [64*SIZE-1:0]  pixels,
    output logic                started,
    output logic                mosi,
    output logic                cs
);
    state_t               state;
    logic [2:0]           frame_cnt;
    logic [64*SIZE-1:0]   pixels_reg;
    logic                 frame_end;
    logic                 load;
    logic                 capture;
    logic                 from_reg;
    logic [2:0]           row;
    logic [64*SIZE-1:0]   src;
    logic [16*SIZE-1:0]   words;

    function automatic logic [7:0] row_byte(input logic [7:0] b);
`ifdef MAX7219_MIRROR_EN
        for (int i = 0; i < 8; i++)
            row_byte[i] = b[7-i];
`else
        row_byte = b;
`endif
    endfunction

    // Row 0 of a refresh is built straight from pixels, since the capture happens on the same edge.
    assign from_reg = (state == ST_UPDATE) && (frame_cnt != 3'(ROW_FRAMES - 1));
    assign capture  = enable && ((state == ST_READY) ||
                      ((state == ST_UPDATE) && frame_end && !from_reg));

    always_comb begin
        row   = from_reg ? frame_cnt + 3'd1 : 3'd0;
        src   = from_reg ? pixels_reg : pixels;
        words = '0;
        for (int d = 0; d < SIZE; d++)
            words[16*d +: 16] = (state == ST_INIT) ? init_word(frame_cnt + 3'd1, INTENSITY)
                                                   : {row_addr(row), row_byte(src[64*d + 8*row +: 8])};
    end

    always_comb begin
        case (state)
            ST_INIT:  load = frame_end && (frame_cnt != 3'(INIT_FRAMES - 1));
            ST_READY: load = enable;
            default:  load = frame_end && (from_reg || enable);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            frame_cnt  <= '0;
            pixels_reg <= '0;
            started    <= 1'b0;
        end else begin
            if (capture)
                pixels_reg <= pixels;
            case (state)
                ST_INIT: if (frame_end) begin
                    if (frame_cnt == 3'(INIT_FRAMES - 1)) begin
                        state     <= ST_READY;
                        started   <= 1'b1;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + 3'd1;
                    end
                end
                ST_READY: if (enable) begin
                    state     <= ST_UPDATE;
                    frame_cnt <= '0;
                end
                default: if (frame_end) begin
                    if (from_reg) begin
                        frame_cnt <= frame_cnt + 3'd1;
                    end else begin
                        frame_cnt <= '0;
                        if (!enable)
                            state <= ST_READY;
                    end
                end
            endcase
        end
    end

    max7219_frame_tx #(
        .SIZE       (SIZE),
        .RESET_WORD (init_word(3'd0, INTENSITY))
    ) u_frame_tx (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .words     (words),
        .frame_end (frame_end),
        .mosi      (mosi),
        .cs        (cs)
    );

endmodule

// File: tb/tb_max7219_matrix_display.sv
// tb/tb_max7219_matrix_display.sv - random refresh stimulus checked against a frame-list model of the MAX7219 chain
module tb_max7219_matrix_display;
    localparam int SIZE = 2;
    localparam int NB   = 16 * SIZE;
    localparam int F    = NB + 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic [64*SIZE-1:0]  pixels = '0;
    logic                started;
    logic                mosi;
    logic                cs;

    max7219_matrix_display #(.SIZE(SIZE), .INTENSITY(4'h8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .pixels  (pixels),
        .started (started),
        .mosi    (mosi),
        .cs      (cs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] data;
        bit            gap_chk;
    } exp_t;

    exp_t exp_q[$];
    int   fall_q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [7:0] b);
`ifdef MAX7219_MIRROR_EN
        for (int i = 0; i < 8; i++)
            ref_byte[i] = b[7-i];
`else
        ref_byte = b;
`endif
    endfunction

    task automatic push_init();
        logic [15:0] w [5] = '{16'h0C01, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00};
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.data    = {SIZE{w[k]}};
            e.gap_chk = (k != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_update(input logic [64*SIZE-1:0] pix, input bit first_gap);
        for (int r = 0; r < 8; r++) begin
            exp_t e;
            e.data = '0;
            for (int d = SIZE - 1; d >= 0; d--)
                e.data = (e.data << 16) | NB'({4'h0, 4'(r + 1), ref_byte(pix[64*d + 8*r +: 8])});
            e.gap_chk = (r != 0) || first_gap;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        repeat (4) @(posedge clk);
    endtask

    // Device-side view: collect bits while cs is low, sampled 1 time unit after each rising edge.
    logic [NB-1:0] acc = '0;
    int            nbits = 0;
    int            hi = 0;
    bit            in_frame = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset_n) begin
            nbits    = 0;
            hi       = 0;
            in_frame = 1'b0;
        end else if (!cs) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                nbits    = 0;
                fall_q.push_back(cyc);
                if (exp_q.size() > 0 && exp_q[0].gap_chk)
                    check_eq("gap_len", 64'(hi), 64'd2);
            end
            acc = {acc[NB-2:0], mosi};
            nbits++;
        end else begin
            if (in_frame) begin
                exp_t e;
                in_frame = 1'b0;
                hi       = 0;
                check_eq("cs_low_len", 64'(nbits), 64'(NB));
                check_eq("frame_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("frame_data", 64'(acc), 64'(e.data));
                end
            end
            hi++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64*SIZE-1:0] pix, pa, pb;
        int k, n0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", 64'(cs), 64'd1);
        check_eq("rst_mosi", 64'(mosi), 64'd0);
        check_eq("rst_started", 64'(started), 64'd0);

        push_init();
        reset_n = 1'b1;
        repeat (169) @(posedge clk);
        #2 check_eq("started_169", 64'(started), 64'd0);
        @(posedge clk);
        #2 check_eq("started_170", 64'(started), 64'd1);
        drain("init_drain");

        for (int it = 0; it < 6; it++) begin
            pix = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (it == 0)
                pix = 128'hA5;
            @(negedge clk);
            pixels = pix;
            enable = 1'b1;
            push_update(pix, 1'b0);
            @(negedge clk);
            enable = 1'b0;
            k = $urandom_range(5, 120);
            repeat (k) @(negedge clk);
            pixels = (it % 2 == 1) ? '1 : {$urandom(), $urandom(), $urandom(), $urandom()};
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            @(posedge clk);
            #2 check_eq("started_in_update", 64'(started), 64'd1);
            drain("update_drain");
        end

        pa = {$urandom(), $urandom(), $urandom(), $urandom()};
        pb = {$urandom(), $urandom(), $urandom(), $urandom()};
        n0 = fall_q.size();
        @(negedge clk);
        pixels = pa;
        enable = 1'b1;
        push_update(pa, 1'b0);
        repeat (100) @(negedge clk);
        pixels = ~pa;
        repeat (172) @(negedge clk);
        pixels = pb;
        push_update(pb, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        pixels = '1;
        drain("b2b_drain");
        check_eq("b2b_count", 64'(fall_q.size() - n0), 64'd16);
        if (fall_q.size() >= n0 + 9)
            check_eq("b2b_spacing", 64'(fall_q[n0+8] - fall_q[n0]), 64'd272);

        pix = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        pixels = pix;
        enable = 1'b1;
        push_update(pix, 1'b0);
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (3*F + 10) @(posedge clk);
        #3;
        check_eq("mid_frame_cs", 64'(cs), 64'd0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_eq("abort_cs", 64'(cs), 64'd1);
        check_eq("abort_mosi", 64'(mosi), 64'd0);
        check_eq("abort_started", 64'(started), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        push_init();
        reset_n = 1'b1;
        repeat (170) @(posedge clk);
        #2 check_eq("restarted_170", 64'(started), 64'd1);
        drain("reinit_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
